// File: rtl/rca_pkg.sv
// Shared definitions for the sequential ripple-carry adder.
//   state_t   : controller states (IDLE / RUN / DONE)
//   DEF_WIDTH : default operand/result width
//   DEF_CHUNK : default number of bits added per clock
package rca_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder made of full-adder cells.
// Ports:
//   i_a, i_b : CHUNK-bit addend slices
//   i_ci     : carry into bit 0
//   o_s      : CHUNK-bit sum slice
//   o_co     : carry out of the slice MSB
//   o_c_msb  : carry into the slice MSB (for signed overflow detection)
module rca_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_ci,
    output logic [CHUNK-1:0] o_s,
    output logic             o_co,
    output logic             o_c_msb
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic w_p;
        assign w_p        = i_a[i] ^ i_b[i];
        assign o_s[i]     = w_p ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_p & w_c[i]);
    end

    assign o_co    = w_c[CHUNK];
    assign o_c_msb = w_c[CHUNK - 1];

endmodule

// File: rtl/seq_rca_adder.sv
// Sequential adder/subtractor: adds one CHUNK-bit slice per clock, LSB slice
// first, through a single rca_chunk instance. Results are presented on a
// one-cycle done pulse and held until the next operation completes.
// Optional feature macro: SEQ_RCA_SUB_EN enables subtraction via op=1
// (B inverted, carry-in 1). Without it op is ignored and only add is built.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   start : request pulse, sampled only while busy=0
//   A, B  : operands, captured on accepted start
//   op    : 0 = add, 1 = subtract (captured with operands)
//   busy  : operation in progress
//   done  : one-cycle pulse, results valid
//   S     : sum/difference
//   Co    : carry out of MSB (subtract: 1 = no borrow)
//   V     : signed overflow
module seq_rca_adder
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V
);

    // WIDTH must be a multiple of CHUNK.
    localparam int unsigned NCH   = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_v;

    logic [IDX_W-1:0] w_base;
    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK-1:0] w_sum;
    logic             w_co;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_part_next;
    logic             w_cin_init;

    assign w_base    = IDX_W'(r_cnt * CHUNK);
    assign w_a_slice = r_a[w_base +: CHUNK];

`ifdef SEQ_RCA_SUB_EN
    logic r_op;

    assign w_b_slice  = r_op ? ~r_b[w_base +: CHUNK] : r_b[w_base +: CHUNK];
    assign w_cin_init = op;
`else
    // op is accepted on the port but has no effect in the add-only build.
    logic w_unused_op;

    assign w_unused_op = op;
    assign w_b_slice   = r_b[w_base +: CHUNK];
    assign w_cin_init  = 1'b0;
`endif

    rca_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_ci   (r_carry),
        .o_s    (w_sum),
        .o_co   (w_co),
        .o_c_msb(w_c_msb)
    );

    // Drop the new slice into its position of the partial result.
    assign w_part_next = r_part | (WIDTH'(w_sum) << w_base);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_part  <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_v     <= 1'b0;
`ifdef SEQ_RCA_SUB_EN
            r_op    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_cnt   <= '0;
                        r_carry <= w_cin_init;
                        r_part  <= '0;
`ifdef SEQ_RCA_SUB_EN
                        r_op    <= op;
`endif
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_part  <= w_part_next;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_s     <= w_part_next;
                        r_co    <= w_co;
                        r_v     <= w_co ^ w_c_msb;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign S    = r_s;
    assign Co   = r_co;
    assign V    = r_v;

endmodule

// File: tb/tb_seq_rca_adder.sv
module tb_seq_rca_adder;

    logic        clk = 1'b0;
    logic        rst    [2];
    logic        st     [2];
    logic        opv    [2];
    logic [15:0] a      [2];
    logic [15:0] b      [2];
    logic        busy_o [2];
    logic        done_o [2];
    logic [15:0] s_o    [2];
    logic        co_o   [2];
    logic        v_o    [2];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    seq_rca_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
        .clk(clk), .reset(rst[0]), .start(st[0]), .A(a[0]), .B(b[0]), .op(opv[0]),
        .busy(busy_o[0]), .done(done_o[0]), .S(s_o[0]), .Co(co_o[0]), .V(v_o[0])
    );

    seq_rca_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .reset(rst[1]), .start(st[1]), .A(a[1]), .B(b[1]), .op(opv[1]),
        .busy(busy_o[1]), .done(done_o[1]), .S(s_o[1]), .Co(co_o[1]), .V(v_o[1])
    );

    // Reference result {V, Co, S} from plain arithmetic.
    function automatic logic [17:0] ref_op(logic [15:0] x, logic [15:0] y, logic o);
        logic [16:0] r;
        logic        sub;
        logic        ov;
`ifdef SEQ_RCA_SUB_EN
        sub = o;
`else
        sub = 1'b0 & o;
`endif
        if (sub) begin
            r  = {1'b0, x} - {1'b0, y};
            ov = (x[15] != y[15]) && (r[15] != x[15]);
            return {ov, ~r[16], r[15:0]};
        end
        r  = {1'b0, x} + {1'b0, y};
        ov = (x[15] == y[15]) && (r[15] != x[15]);
        return {ov, r[16], r[15:0]};
    endfunction

    function automatic int nch_of(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Behavioural model: countdown of remaining cycles plus pending result.
    int          m_rem  [2];
    logic        m_busy [2];
    logic        m_done [2];
    logic [17:0] m_res  [2];
    logic [17:0] p_res  [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                m_rem[k]  <= 0;
                m_busy[k] <= 1'b0;
                m_done[k] <= 1'b0;
                m_res[k]  <= '0;
                p_res[k]  <= '0;
            end else if (m_busy[k]) begin
                m_rem[k] <= m_rem[k] - 1;
                if (m_rem[k] == 1) begin
                    m_busy[k] <= 1'b0;
                    m_done[k] <= 1'b1;
                    m_res[k]  <= p_res[k];
                end
            end else begin
                m_done[k] <= 1'b0;
                if (st[k]) begin
                    p_res[k]  <= ref_op(a[k], b[k], opv[k]);
                    m_busy[k] <= 1'b1;
                    m_rem[k]  <= nch_of(k);
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [15:0] got,
                       input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, k, $time, got, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("busy", k, {15'd0, busy_o[k]}, {15'd0, m_busy[k]});
                chk("done", k, {15'd0, done_o[k]}, {15'd0, m_done[k]});
                chk("S",    k, s_o[k], m_res[k][15:0]);
                chk("Co",   k, {15'd0, co_o[k]}, {15'd0, m_res[k][16]});
                chk("V",    k, {15'd0, v_o[k]},  {15'd0, m_res[k][17]});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int k, input logic [15:0] x, input logic [15:0] y,
                         input logic o);
        st[k]  = 1'b1;
        a[k]   = x;
        b[k]   = y;
        opv[k] = o;
        @(negedge clk);
        st[k]  = 1'b0;
    endtask

    task automatic wait_done(input int k, input int lat, input int pre, input string name);
        int c;
        c = pre;
        while (done_o[k] !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk(name, k, 16'(c), 16'(lat));
    endtask

    task automatic check_res(input int k, input logic [15:0] es, input logic eco,
                             input logic ev, input string name);
        chk({name, "_S"},  k, s_o[k], es);
        chk({name, "_Co"}, k, {15'd0, co_o[k]}, {15'd0, eco});
        chk({name, "_V"},  k, {15'd0, v_o[k]},  {15'd0, ev});
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            st[k]  = 1'b0;
            opv[k] = 1'b0;
            a[k]   = '0;
            b[k]   = '0;
        end
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk("rst_busy", 0, {15'd0, busy_o[0]}, 16'd0);
        chk("rst_done", 0, {15'd0, done_o[0]}, 16'd0);
        chk("rst_S",    0, s_o[0], 16'h0000);
        @(negedge clk);

        // Carry ripples through every slice.
        issue(0, 16'hFFFF, 16'h0001, 1'b0);
        wait_done(0, 4, 0, "lat_ffff");
        check_res(0, 16'h0000, 1'b1, 1'b0, "ffff_p1");
        @(negedge clk);
        chk("done_width", 0, {15'd0, done_o[0]}, 16'd0);

        // Signed overflow, then a back-to-back start from DONE.
        issue(0, 16'h7FFF, 16'h0001, 1'b0);
        wait_done(0, 4, 0, "lat_7fff");
        check_res(0, 16'h8000, 1'b0, 1'b1, "7fff_p1");
        issue(0, 16'h1234, 16'h0000, 1'b0);
        wait_done(0, 4, 0, "lat_b2b");
        check_res(0, 16'h1234, 1'b0, 1'b0, "b2b");
        @(negedge clk);

        // Subtract requests; add-only build treats op=1 as add.
        issue(0, 16'h0005, 16'h0007, 1'b1);
        wait_done(0, 4, 0, "lat_sub1");
`ifdef SEQ_RCA_SUB_EN
        check_res(0, 16'hFFFE, 1'b0, 1'b0, "sub_5_7");
`else
        check_res(0, 16'h000C, 1'b0, 1'b0, "nosub_5_7");
`endif
        @(negedge clk);
        issue(0, 16'h8000, 16'h0001, 1'b1);
        wait_done(0, 4, 0, "lat_sub2");
`ifdef SEQ_RCA_SUB_EN
        check_res(0, 16'h7FFF, 1'b1, 1'b1, "sub_8000_1");
`else
        check_res(0, 16'h8001, 1'b0, 1'b0, "nosub_8000_1");
`endif
        @(negedge clk);

        // Start while busy must be ignored.
        issue(0, 16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        st[0] = 1'b1;
        a[0]  = 16'hAAAA;
        b[0]  = 16'h5555;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0, 4, 2, "lat_ignored");
        check_res(0, 16'h0002, 1'b0, 1'b0, "ignored");
        @(negedge clk);

        // Reset in the middle of an operation.
        issue(0, 16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("midrst_busy", 0, {15'd0, busy_o[0]}, 16'd0);
        chk("midrst_done", 0, {15'd0, done_o[0]}, 16'd0);
        check_res(0, 16'h0000, 1'b0, 1'b0, "midrst");
        issue(0, 16'h00FF, 16'h0F01, 1'b0);
        wait_done(0, 4, 0, "lat_fresh");
        check_res(0, 16'h1000, 1'b0, 1'b0, "fresh");
        @(negedge clk);

        // Single-slice configuration.
        issue(1, 16'hFFFF, 16'hFFFF, 1'b0);
        wait_done(1, 1, 0, "lat_c16");
        check_res(1, 16'hFFFE, 1'b1, 1'b0, "c16");
        @(negedge clk);

        // Random traffic on both instances, occasional resets.
        for (int n = 0; n < 800; n++) begin
            for (int k = 0; k < 2; k++) begin
                st[k]  = ($urandom_range(0, 3) == 0);
                a[k]   = 16'($urandom);
                b[k]   = 16'($urandom);
                opv[k] = 1'($urandom);
                rst[k] = ($urandom_range(0, 99) == 0);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            st[k]  = 1'b0;
            rst[k] = 1'b0;
        end
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
